// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
package uart_pkg;

   localparam int          UART_DATA_W  = 8;
   localparam logic [31:0] BAUD_MIN_DIV = 32'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: register-side bus of the UART receiver (configuration, read strobe, status).
interface uart_rx_if;
   import uart_pkg::*;

   logic [31:0]            baud_div;
   logic                   rx_rd;
   logic [UART_DATA_W-1:0] rx_data;
   logic                   rx_valid;
   logic                   rx_busy;
   logic                   frame_err;
   logic                   overrun;
   logic                   parity_err;

   modport master (
      output baud_div, rx_rd,
      input  rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err
   );

   modport slave (
      input  baud_div, rx_rd,
      output rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err
   );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: SYNC_STAGES-deep flop chain bringing an asynchronous line into the clk domain.
// Flops reset to 1 so an idle-high line shows no edge when reset is released.
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // shift the raw line through the synchroniser chain
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, start + 8 data (LSB first) + stop, with a one-byte holding register.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data and the stop bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic     clk,
   input  logic     arst_n,
   input  logic     rx_serial,
   uart_rx_if.slave bus
);

   logic                   rxs;
   logic                   rxs_prev_q;
   uart_state_e            state_q, state_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [31:0]            div_q, div_d;
   logic [2:0]             bit_q, bit_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;
   logic                   drop_q, drop_d;
   logic                   cnt_exp;
`ifdef UART_RX_PARITY_EN
   logic                   perr_q, perr_d;
`endif

   // Effective divider: anything below the minimum is raised to it (P = div+1 >= 4).
   function automatic logic [31:0] eff_div(input logic [31:0] d);
      return (d < BAUD_MIN_DIV) ? BAUD_MIN_DIV : d;
   endfunction

   // Half bit period H = P>>1 with P = div+1, computed wide so div=all-ones cannot wrap.
   function automatic logic [31:0] half_period(input logic [31:0] d);
      return 32'(({1'b0, d} + 33'd1) >> 1);
   endfunction

`ifdef UART_RX_PARITY_EN
   // Even parity: data bits plus parity bit must contain an even number of ones.
   function automatic logic parity_bad(input logic [UART_DATA_W-1:0] d, input logic p);
      return (^d) ^ p;
   endfunction
`endif

   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .arst_n (arst_n),
      .d_i    (rx_serial),
      .q_o    (rxs)
   );

   // state and datapath registers; reset discards any partial frame
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         rxs_prev_q <= 1'b1;
         cnt_q      <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         drop_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rxs_prev_q <= rxs;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         drop_q     <= drop_d;
`ifdef UART_RX_PARITY_EN
         perr_q     <= perr_d;
`endif
      end
   end

   // next-state logic: bit timing, sampling, and holding-register update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      drop_d  = drop_q;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
      cnt_exp = (cnt_q == '0);

      // A read only matters when a byte is held; a load below overrides it.
      if (bus.rx_rd && valid_q) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // Edge detect (not level) so a line stuck low never retriggers.
            if (rxs_prev_q && !rxs) begin
               state_d = ST_START;
               div_d   = eff_div(bus.baud_div);
               cnt_d   = half_period(eff_div(bus.baud_div));
               bit_d   = '0;
               drop_d  = 1'b0;
            end
         end
         ST_START: begin
            if (!cnt_exp) begin
               cnt_d = cnt_q - 32'd1;
            end else if (!rxs) begin
               state_d = ST_DATA;
               cnt_d   = div_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!cnt_exp) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               shift_d = {rxs, shift_q[UART_DATA_W-1:1]};
               cnt_d   = div_q;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!cnt_exp) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               cnt_d   = div_q;
               state_d = ST_STOP;
               if (parity_bad(shift_q, rxs)) begin
                  perr_d = 1'b1;
                  drop_d = 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (!cnt_exp) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               state_d = ST_IDLE;
               if (!rxs) begin
                  ferr_d = 1'b1;
               end else if (!drop_q) begin
                  if (valid_q) begin
                     ovr_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.rx_busy   = (state_q != ST_IDLE);
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected bytes/flags are queued and popped by a monitor.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int EV_VALID = 0;
   localparam int EV_FERR  = 1;
   localparam int EV_OVR   = 2;
   localparam int EV_PERR  = 3;
   localparam int P        = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic arst_n;
   logic rx_line;
   int   cyc = 0;
   int   t_start;
   int   t_valid;
   int   errors = 0;
   int   checks = 0;
   ev_t  expq[$];

   uart_rx_if bus();

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .rx_serial (rx_line),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.data = d;
      expq.push_back(e);
   endtask

   task automatic got_event(input int kind, input logic [7:0] d);
      ev_t e;
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d data %0h, expected no event", kind, d);
      end else begin
         e = expq.pop_front();
         chk("event_kind", kind, e.kind);
         if (kind == EV_VALID) chk("event_rx_data", {24'd0, d}, {24'd0, e.data});
      end
   endtask

   task automatic monitor();
      logic vprev = 1'b0;
      forever begin
         @(negedge clk);
         if (arst_n) begin
            if (bus.rx_valid && !vprev) begin
               t_valid = cyc;
               got_event(EV_VALID, bus.rx_data);
            end
            if (bus.frame_err)  got_event(EV_FERR, 8'h00);
            if (bus.overrun)    got_event(EV_OVR, 8'h00);
            if (bus.parity_err) got_event(EV_PERR, 8'h00);
         end
         vprev = bus.rx_valid;
      end
   endtask

   task automatic send_bit(input logic b, input int p);
      rx_line = b;
      repeat (p) @(negedge clk);
   endtask

   task automatic send_data(input logic [7:0] d, input int p);
      t_start = cyc;
      send_bit(1'b0, p);
      for (int i = 0; i < 8; i++) send_bit(d[i], p);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int p);
      send_data(d, p);
`ifdef UART_RX_PARITY_EN
      send_bit(^d, p);
`endif
      send_bit(stop_b, p);
      rx_line = 1'b1;
   endtask

   task automatic rd_pulse();
      bus.rx_rd = 1'b1;
      @(negedge clk);
      bus.rx_rd = 1'b0;
   endtask

   initial begin
      arst_n       = 1'b0;
      rx_line      = 1'b1;
      bus.baud_div = 32'd15;
      bus.rx_rd    = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      chk("reset_rx_data", {24'd0, bus.rx_data}, 32'h0);
      chk("reset_rx_valid", bus.rx_valid, 1'b0);
      chk("reset_rx_busy", bus.rx_busy, 1'b0);
      chk("reset_frame_err", bus.frame_err, 1'b0);
      chk("reset_overrun", bus.overrun, 1'b0);
      chk("reset_parity_err", bus.parity_err, 1'b0);
      arst_n = 1'b1;
      send_bit(1'b1, 2 * P);

      // basic frame 0xA5
      expect_ev(EV_VALID, 8'hA5);
      send_frame(8'hA5, 1'b1, P);
      send_bit(1'b1, 2 * P);
      chk("a5_latency_window",
          ((t_valid - t_start) >= FRAME_BITS * P - 10) && ((t_valid - t_start) <= FRAME_BITS * P + 8), 1'b1);
      chk("a5_busy_after", bus.rx_busy, 1'b0);
      chk("a5_valid", bus.rx_valid, 1'b1);
      chk("a5_data", {24'd0, bus.rx_data}, 32'hA5);
      rd_pulse();
      chk("a5_valid_after_rd", bus.rx_valid, 1'b0);

      // 4-clock low glitch: false start
      send_bit(1'b0, 4);
      chk("glitch_busy_in_start", bus.rx_busy, 1'b1);
      send_bit(1'b1, 3 * P);
      chk("glitch_busy_after", bus.rx_busy, 1'b0);
      chk("glitch_valid", bus.rx_valid, 1'b0);

      // 0x3C with stop bit 0, line then held low
      expect_ev(EV_FERR, 8'h00);
      send_frame(8'h3C, 1'b0, P);
      rx_line = 1'b0;
      repeat (3 * P) @(negedge clk);
      chk("ferr_no_retrigger_busy", bus.rx_busy, 1'b0);
      chk("ferr_valid", bus.rx_valid, 1'b0);
      send_bit(1'b1, 2 * P);
      chk("ferr_busy_after_high", bus.rx_busy, 1'b0);

      // overrun: 0x11 then 0x22, no read in between
      expect_ev(EV_VALID, 8'h11);
      expect_ev(EV_OVR, 8'h00);
      send_frame(8'h11, 1'b1, P);
      send_bit(1'b1, 2 * P);
      send_frame(8'h22, 1'b1, P);
      send_bit(1'b1, 2 * P);
      chk("ovr_data_kept", {24'd0, bus.rx_data}, 32'h11);
      chk("ovr_valid", bus.rx_valid, 1'b1);
      rd_pulse();
      chk("ovr_valid_after_rd", bus.rx_valid, 1'b0);
      rd_pulse();
      chk("idle_rd_valid", bus.rx_valid, 1'b0);
      chk("idle_rd_data", {24'd0, bus.rx_data}, 32'h11);

      // read strobe held through a load: load wins, then the read clears it
      expect_ev(EV_VALID, 8'hC3);
      bus.rx_rd = 1'b1;
      send_frame(8'hC3, 1'b1, P);
      send_bit(1'b1, 2 * P);
      bus.rx_rd = 1'b0;
      chk("rdload_data", {24'd0, bus.rx_data}, 32'hC3);
      chk("rdload_valid_cleared", bus.rx_valid, 1'b0);

      // baud_div 0 is clamped to 3 (P = 4)
      bus.baud_div = 32'd0;
      expect_ev(EV_VALID, 8'h96);
      send_frame(8'h96, 1'b1, 4);
      send_bit(1'b1, 4 * 4);
      chk("clamp_data", {24'd0, bus.rx_data}, 32'h96);
      chk("clamp_valid", bus.rx_valid, 1'b1);
      rd_pulse();
      bus.baud_div = 32'd15;
      send_bit(1'b1, P);

      // reset after 4 data bits of 0x5A, then 0x7E
      send_bit(1'b0, P);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b0, P);
      chk("midframe_busy", bus.rx_busy, 1'b1);
      arst_n  = 1'b0;
      rx_line = 1'b1;
      @(negedge clk);
      chk("midreset_busy", bus.rx_busy, 1'b0);
      chk("midreset_valid", bus.rx_valid, 1'b0);
      chk("midreset_data", {24'd0, bus.rx_data}, 32'h0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      send_bit(1'b1, 2 * P);
      expect_ev(EV_VALID, 8'h7E);
      send_frame(8'h7E, 1'b1, P);
      send_bit(1'b1, 2 * P);
      chk("after_reset_data", {24'd0, bus.rx_data}, 32'h7E);
      rd_pulse();

`ifdef UART_RX_PARITY_EN
      // 0x01 with wrong parity bit, then with correct parity bit
      expect_ev(EV_PERR, 8'h00);
      send_data(8'h01, P);
      send_bit(1'b0, P);
      send_bit(1'b1, 3 * P);
      chk("par_bad_valid", bus.rx_valid, 1'b0);
      expect_ev(EV_VALID, 8'h01);
      send_data(8'h01, P);
      send_bit(1'b1, P);
      send_bit(1'b1, 3 * P);
      chk("par_good_data", {24'd0, bus.rx_data}, 32'h01);
      rd_pulse();
`endif

      send_bit(1'b1, P);
      chk("pending_events", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the flops in the rx_serial synchroniser (legal 2..4).
REQ-002 clk  input  1  SHALL be the system clock; all state on rising edge.
REQ-003 arst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 rx_serial  input  1  SHALL be the asynchronous serial line, idle high.
REQ-005 baud_div  input  32  SHALL set bit period P = baud_div+1 clocks; sampled at start-bit detection, held for the frame.
REQ-006 rx_rd  input  1  SHALL be a one-cycle APB-side read strobe consuming the held byte.
REQ-007 rx_data  output  8  SHALL carry the last received byte, LSB first on the line.
REQ-008 rx_valid  output  1  SHALL indicate rx_data holds an unread byte.
REQ-009 rx_busy  output  1  SHALL be high in every state except IDLE.
REQ-010 frame_err  output  1  SHALL pulse one cycle when the stop-bit sample is 0.
REQ-011 overrun  output  1  SHALL pulse one cycle when a good frame completes while rx_valid=1.
REQ-012 parity_err  output  1  SHALL pulse one cycle on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-013 rx_serial SHALL pass through SYNC_STAGES flops; all decisions use the synchronised signal rxs.
REQ-014 FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only with parity compiled in.
REQ-015 IDLE->START SHALL occur on a 1->0 transition of rxs; a counter is loaded with half period H = P>>1.
REQ-016 In START, at counter expiry, rxs=0 SHALL go to DATA with counter reloaded to P-1, and rxs=1 SHALL be a false start returning to IDLE with no flag raised.
REQ-017 In DATA, each counter expiry SHALL shift rxs into a shift register (LSB first) and reload P-1; after the 8th sample, go to PARITY or STOP.
REQ-018 In STOP, at expiry, rxs=1 SHALL be a good frame and rxs=0 SHALL pulse frame_err, discard the byte and return to IDLE.
REQ-019 Good frame with rx_valid=0: rx_data SHALL load and rx_valid SHALL set on the following cycle, with return to IDLE.
REQ-020 Good frame with rx_valid=1: rx_data SHALL stay unchanged, the new byte SHALL be discarded and overrun SHALL pulse.
REQ-021 rx_rd SHALL clear rx_valid the next cycle; rx_rd with rx_valid=0 SHALL be ignored; a load and an rx_rd in the same cycle SHALL leave rx_valid=1 with the new data.
REQ-022 baud_div below 3 SHALL be treated as 3 (P minimum 4).
REQ-023 A new start SHALL be detected no earlier than the cycle after STOP exits; a line held low after frame_err SHALL NOT retrigger until rxs has returned to 1.

Reset
REQ-024 Asserting arst_n SHALL force IDLE, sync flops to 1, rx_data=0, rx_valid=0, rx_busy=0, and all error pulses to 0, including mid-frame; the partial byte SHALL be lost.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data; the PARITY state samples it at P spacing; a mismatch pulses parity_err and drops the byte.
REQ-026 Macro UART_RX_PARITY_EN undefined: the frame is start+8 data+stop, and parity_err is constant 0.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enum, UART_DATA_W=8 and BAUD_MIN_DIV=3, shared with the transmitter.
REQ-028 Sub-module uart_sync SHALL implement the parameterised synchroniser.

Verification
REQ-029 baud_div=15, byte 0xA5 framed 0,1,0,1,0,0,1,0,1,1 -> rx_valid rises with rx_data=0xA5 about 10*16 cycles after the start edge; rx_busy is 0 afterwards.
REQ-030 Low glitch of 4 clocks with baud_div=15 -> FSM returns to IDLE, rx_valid stays 0, no flags.
REQ-031 Byte 0x3C with stop bit 0 -> frame_err pulses once, rx_valid stays 0, and there is no retrigger until the line is high.
REQ-032 Two bytes 0x11 then 0x22 without rx_rd -> rx_data=0x11, overrun pulses once; after rx_rd, rx_valid clears.
REQ-033 Reset asserted after 4 data bits, then byte 0x7E sent -> the first partial byte is lost and rx_data=0x7E.
REQ-034 With UART_RX_PARITY_EN, byte 0x01 with parity bit 0 -> parity_err pulses; with parity bit 1 -> rx_data=0x01.
